// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants, direction encoding and blitter FSM states.
package vga_pkg;

    localparam int unsigned REAL_WIDTH  = 640;
    localparam int unsigned REAL_HEIGHT = 480;
    localparam int unsigned FB_AW       = 19;

    localparam logic [7:0] KEY_DEFAULT = 8'hE3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite scan counters, ROM address, and destination pipe aligned to ROM latency.
// BLIT_ROT_EN enables rotation of the source read by the latched dir.
module blit_addr_gen
    import vga_pkg::*;
#(
    parameter int unsigned SPR_W  = 32,
    parameter int unsigned SPR_H  = 32,
    parameter int unsigned ROM_AW = 10
) (
    input  logic              clk25m,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        dir,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              last,
    output logic              pix_valid,
    output logic [10:0]       pix_dx,
    output logic [10:0]       pix_dy
);

    localparam int unsigned CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    logic [CXW-1:0]    cx_q, cx_d, sx;
    logic [CYW-1:0]    cy_q, cy_d, sy;
    logic [9:0]        px_q, px_d, py_q, py_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              v1_q, v1_d, v2_q;
    logic [10:0]       dx1_q, dx1_d, dy1_q, dy1_d, dx2_q, dy2_q;

    always_comb begin
        px_d = px_q;
        py_d = py_q;
        cx_d = cx_q;
        cy_d = cy_q;
        if (load) begin
            px_d = pos_x;
            py_d = pos_y;
            cx_d = '0;
            cy_d = '0;
        end else if (step) begin
            if (cx_q == CXW'(SPR_W - 1)) begin
                cx_d = '0;
                cy_d = cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

`ifdef BLIT_ROT_EN
    logic [1:0] dir_q, dir_d;

    always_comb begin
        dir_d = load ? dir : dir_q;
        case (dir_d)
            DIR_RIGHT: begin
                sx = CXW'(cy_d);
                sy = CYW'(SPR_W - 1) - CYW'(cx_d);
            end
            DIR_DOWN: begin
                sx = CXW'(SPR_W - 1) - cx_d;
                sy = CYW'(SPR_H - 1) - cy_d;
            end
            DIR_LEFT: begin
                sx = CXW'(SPR_H - 1) - CXW'(cy_d);
                sy = CYW'(cx_d);
            end
            default: begin
                sx = cx_d;
                sy = cy_d;
            end
        endcase
    end

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) dir_q <= DIR_UP;
        else        dir_q <= dir_d;
    end
`else
    logic dir_unused;
    assign dir_unused = ^dir;
    assign sx = cx_d;
    assign sy = cy_d;
`endif

    // Address and destination are computed from the next counter value so
    // they register together with the pixel being issued.
    always_comb begin
        v1_d       = load | step;
        rom_addr_d = rom_addr_q;
        dx1_d      = dx1_q;
        dy1_d      = dy1_q;
        if (v1_d) begin
            rom_addr_d = ROM_AW'(sy) * ROM_AW'(SPR_W) + ROM_AW'(sx);
            dx1_d      = 11'(px_d) + 11'(cx_d);
            dy1_d      = 11'(py_d) + 11'(cy_d);
        end
    end

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            cx_q       <= '0;
            cy_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            dx1_q      <= '0;
            dy1_q      <= '0;
            dx2_q      <= '0;
            dy2_q      <= '0;
        end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            px_q       <= px_d;
            py_q       <= py_d;
            rom_addr_q <= rom_addr_d;
            v1_q       <= v1_d;
            v2_q       <= v1_q;
            dx1_q      <= dx1_d;
            dy1_q      <= dy1_d;
            dx2_q      <= dx1_q;
            dy2_q      <= dy1_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign last      = (cx_q == CXW'(SPR_W - 1)) && (cy_q == CYW'(SPR_H - 1));
    assign pix_valid = v2_q;
    assign pix_dx    = dx2_q;
    assign pix_dy    = dy2_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite-ROM to RGB332 frame-buffer blitter with colour-key and screen clipping.
// Optional BLIT_ROT_EN rotates the sprite by dir (see blit_addr_gen).
module sprite_blitter
    import vga_pkg::*;
#(
    parameter int unsigned SPR_W  = 32,
    parameter int unsigned SPR_H  = 32,
    parameter int unsigned ROM_AW = 10,
    parameter logic [7:0]  KEY    = KEY_DEFAULT
) (
    input  logic              clk25m,
    input  logic              rst_n,
    input  logic              start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        dir,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    output logic              busy,
    output logic              done
);

    blit_state_t       state_q, state_d;
    logic              drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fb_we_q, fb_we_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic              load, step, last, pix_valid;
    logic [10:0]       pix_dx, pix_dy;
    logic              in_screen;
    logic [FB_AW-1:0]  lin_addr;

    blit_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ROM_AW (ROM_AW)
    ) u_addr_gen (
        .clk25m    (clk25m),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .dir       (dir),
        .rom_addr  (rom_addr),
        .last      (last),
        .pix_valid (pix_valid),
        .pix_dx    (pix_dx),
        .pix_dy    (pix_dy)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (last) begin
                    drain_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // y*640 as (y<<9)+(y<<7); the frame width is fixed by the scan-out.
    assign lin_addr  = FB_AW'({pix_dy, 9'b0}) + FB_AW'({pix_dy, 7'b0}) + FB_AW'(pix_dx);
    assign in_screen = (pix_dx < 11'(REAL_WIDTH)) && (pix_dy < 11'(REAL_HEIGHT));

    always_comb begin
        fb_we_d   = pix_valid && (rom_data != KEY) && in_screen;
        fb_addr_d = fb_we_d ? lin_addr : fb_addr_q;
        fb_data_d = fb_we_d ? rom_data : fb_data_q;
    end

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected writes queued per blit, checked by a monitor.
`timescale 1ns/1ps
module tb_sprite_blitter;
    import vga_pkg::*;

    localparam int N = 1024;

    logic        clk25m = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [9:0]  pos_x  = '0;
    logic [9:0]  pos_y  = '0;
    logic [1:0]  dir    = '0;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we, busy, done;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  tick        = 0;
    int  rom_mode    = 0;
    int  wr_cnt      = 0;
    int  last_we_tick, first_addr, first_data, last_addr;

    sprite_blitter #(
        .SPR_W  (32),
        .SPR_H  (32),
        .ROM_AW (10),
        .KEY    (8'hE3)
    ) dut (
        .clk25m   (clk25m),
        .rst_n    (rst_n),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .dir      (dir),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .busy     (busy),
        .done     (done)
    );

    always #20 clk25m = ~clk25m;

    always @(posedge clk25m) tick <= tick + 1;

    // mode 0: solid 8'h01; mode 1: checkerboard 1C/key; mode 2: pixel = sx
    function automatic logic [7:0] rom_word(input int mode, input logic [9:0] a);
        case (mode)
            1:       return (a[0] ^ a[5]) ? 8'hE3 : 8'h1C;
            2:       return {3'b000, a[4:0]};
            default: return 8'h01;
        endcase
    endfunction

    always @(posedge clk25m) rom_data <= rom_word(rom_mode, rom_addr);

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk25m) begin
        if (rst_n && fb_we) begin
            wr_cnt++;
            last_we_tick = tick;
            last_addr    = fb_addr;
            if (wr_cnt == 1) begin
                first_addr = fb_addr;
                first_data = fb_data;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", fb_addr, -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("fb_addr", fb_addr, e.addr);
                chk("fb_data", fb_data, e.data);
            end
        end
    end

    task automatic build_model(input int px, input int py, input int d, input int mode);
        exp_q.delete();
        for (int cy = 0; cy < 32; cy++) begin
            for (int cx = 0; cx < 32; cx++) begin
                int sx, sy, dx, dy;
                logic [7:0] v;
`ifdef BLIT_ROT_EN
                case (d)
                    1:       begin sx = cy;      sy = 31 - cx; end
                    2:       begin sx = 31 - cx; sy = 31 - cy; end
                    3:       begin sx = 31 - cy; sy = cx;      end
                    default: begin sx = cx;      sy = cy;      end
                endcase
`else
                sx = cx;
                sy = cy;
                if (d > 3) sx = 0;
`endif
                v  = rom_word(mode, 10'(sy * 32 + sx));
                dx = px + cx;
                dy = py + cy;
                if (v != 8'hE3 && dx < 640 && dy < 480)
                    exp_q.push_back('{addr: dy * 640 + dx, data: int'(v)});
            end
        end
    endtask

    task automatic blit(input string tag, input int px, input int py, input int d,
                        input int mode, input int extra_k, input int exp_writes,
                        input int exp_last_k, input int exp_first, input int exp_first_data,
                        input int exp_last_addr);
        int t0, dones, done_k, busy_err;
        build_model(px, py, d, mode);
        @(negedge clk25m);
        rom_mode = mode;
        wr_cnt   = 0;
        pos_x    = 10'(px);
        pos_y    = 10'(py);
        dir      = 2'(d);
        start    = 1'b1;
        t0       = tick;
        dones    = 0;
        done_k   = -1;
        busy_err = 0;
        for (int k = 1; k <= N + 8; k++) begin
            @(negedge clk25m);
            start = (k == extra_k);
            if (busy !== (k <= N + 2)) busy_err++;
            if (done === 1'b1) begin
                dones++;
                done_k = k;
            end
        end
        start = 1'b0;
        chk({tag, ":done_count"}, dones, 1);
        chk({tag, ":done_cycle"}, done_k, N + 3);
        chk({tag, ":busy_window_errors"}, busy_err, 0);
        chk({tag, ":write_count"}, wr_cnt, exp_writes);
        chk({tag, ":missing_writes"}, exp_q.size(), 0);
        if (exp_writes > 0) begin
            chk({tag, ":last_write_cycle"}, last_we_tick - t0, exp_last_k);
            chk({tag, ":first_addr"}, first_addr, exp_first);
            chk({tag, ":first_data"}, first_data, exp_first_data);
            chk({tag, ":last_addr"}, last_addr, exp_last_addr);
        end
        exp_q.delete();
    endtask

    initial begin
        int t0;
        #50;
        chk("reset:rom_addr", rom_addr, 0);
        chk("reset:fb_addr", fb_addr, 0);
        chk("reset:fb_data", fb_data, 0);
        chk("reset:fb_we", fb_we, 0);
        chk("reset:busy", busy, 0);
        chk("reset:done", done, 0);
        @(negedge clk25m);
        rst_n = 1'b1;
        repeat (3) @(negedge clk25m);

        blit("solid", 0, 0, 0, 0, 0, 1024, 1026, 0, 8'h01, 19871);
        blit("checker", 100, 50, 0, 1, 0, 512, 1026, 32100, 8'h1C, 51971);
        blit("clip_br", 620, 470, 0, 0, 0, 200, 310, 301420, 8'h01, 307199);
        blit("restart", 0, 0, 0, 0, 500, 1024, 1026, 0, 8'h01, 19871);
        blit("clip_all", 1023, 1023, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-blit
        build_model(0, 0, 0, 0);
        @(negedge clk25m);
        rom_mode = 0;
        wr_cnt   = 0;
        pos_x    = '0;
        pos_y    = '0;
        dir      = '0;
        start    = 1'b1;
        t0       = tick;
        @(negedge clk25m);
        start = 1'b0;
        repeat (299) @(negedge clk25m);
        chk("abort:cycle", tick - t0, 300);
        #5 rst_n = 1'b0;
        #1;
        chk("abort:writes_before", wr_cnt, 298);
        chk("abort:rom_addr", rom_addr, 0);
        chk("abort:fb_addr", fb_addr, 0);
        chk("abort:fb_data", fb_data, 0);
        chk("abort:fb_we", fb_we, 0);
        chk("abort:busy", busy, 0);
        chk("abort:done", done, 0);
        exp_q.delete();
        wr_cnt = 0;
        repeat (3) @(negedge clk25m);
        rst_n = 1'b1;
        repeat (40) @(negedge clk25m);
        chk("abort:writes_after_release", wr_cnt, 0);
        chk("abort:busy_after_release", busy, 0);

        blit("after_abort", 0, 0, 0, 0, 0, 1024, 1026, 0, 8'h01, 19871);

`ifdef BLIT_ROT_EN
        blit("rot_dir1", 0, 0, 1, 2, 0, 1024, 1026, 0, 0, 19871);
        blit("rot_dir2", 0, 0, 2, 2, 0, 1024, 1026, 0, 31, 19871);
`else
        blit("dir1_ignored", 0, 0, 1, 2, 0, 1024, 1026, 0, 0, 19871);
        blit("dir2_ignored", 0, 0, 2, 2, 0, 1024, 1026, 0, 0, 19871);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
